// File: rtl/tank_ctrl_pkg.sv
// Shared types and decode helpers for the tank lever mapper.
// Tread state and target enums, the joystick-to-target decode functions, and counter sizing.
package tank_ctrl_pkg;

    typedef enum logic [1:0] {NEU, FWD, BCK, DEAD} tread_state_t;
    typedef enum logic [1:0] {TGT_N, TGT_F, TGT_B} target_t;

    typedef struct packed {
        target_t b;
        target_t a;
    } tgt_pair_t;

    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Joystick code is {up, down, left, right}.
    function automatic tgt_pair_t table_decode(input logic [3:0] code);
        tgt_pair_t t;
        t.a = TGT_N;
        t.b = TGT_N;
        case (code)
            4'b1010: begin t.a = TGT_N; t.b = TGT_F; end
            4'b1000: begin t.a = TGT_F; t.b = TGT_F; end
            4'b1001: begin t.a = TGT_F; t.b = TGT_N; end
            4'b0001: begin t.a = TGT_F; t.b = TGT_B; end
            4'b0101: begin t.a = TGT_B; t.b = TGT_N; end
            4'b0100: begin t.a = TGT_B; t.b = TGT_B; end
            4'b0110: begin t.a = TGT_N; t.b = TGT_B; end
            4'b0010: begin t.a = TGT_B; t.b = TGT_F; end
            default: ;
        endcase
        return t;
    endfunction

    // One axis pair {forward, backward}: exactly one bit set selects a direction.
    function automatic target_t axis_decode(input logic [1:0] fb);
        target_t t;
        case (fb)
            2'b10:   t = TGT_F;
            2'b01:   t = TGT_B;
            default: t = TGT_N;
        endcase
        return t;
    endfunction

    function automatic tgt_pair_t direct_decode(input logic [3:0] code);
        tgt_pair_t t;
        t.a = axis_decode(code[3:2]);
        t.b = axis_decode(code[1:0]);
        return t;
    endfunction

    function automatic tread_state_t target_state(input target_t t);
        tread_state_t s;
        case (t)
            TGT_F:   s = FWD;
            TGT_B:   s = BCK;
            default: s = NEU;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/tank_lever_mapper_if.sv
// Joystick inputs and tread drive outputs of the tank lever mapper.
interface tank_lever_mapper_if #(
    parameter int NUM_PLAYERS = 2
);
    logic                     tick;
    logic                     mode;
    logic [4*NUM_PLAYERS-1:0] joy;
    logic [2*NUM_PLAYERS-1:0] tread_fw;
    logic [2*NUM_PLAYERS-1:0] tread_bk;

    modport master (output tick, mode, joy, input tread_fw, tread_bk);
    modport slave  (input tick, mode, joy, output tread_fw, tread_bk);
endinterface

// File: rtl/tread_fsm.sv
// One tread: follows its target direction, forcing a neutral dwell on any reversal.
module tread_fsm
    import tank_ctrl_pkg::*;
#(
    parameter int DEAD_TICKS = 3
) (
    input  logic    clk_sys,
    input  logic    reset,
    input  logic    tick,
    input  target_t target,
    output logic    fw,
    output logic    bk
);
    tread_state_t     state_q, state_n;
    logic [CNT_W-1:0] dcnt_q, dcnt_n;

    always_comb begin
        state_n = state_q;
        dcnt_n  = dcnt_q;
        if (tick) begin
            unique case (state_q)
                NEU, FWD, BCK: begin
                    if ((state_q == FWD && target == TGT_B) ||
                        (state_q == BCK && target == TGT_F)) begin
                        state_n = DEAD;
                        dcnt_n  = CNT_W'(DEAD_TICKS);
                    end else begin
                        state_n = target_state(target);
                    end
                end
                // The dwell always runs to completion, whatever the target does meanwhile.
                DEAD: begin
                    dcnt_n = dcnt_q - CNT_W'(1);
                    if (dcnt_n == '0) state_n = target_state(target);
                end
                default: state_n = NEU;
            endcase
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q <= NEU;
            dcnt_q  <= '0;
            fw      <= 1'b0;
            bk      <= 1'b0;
        end else begin
            state_q <= state_n;
            dcnt_q  <= dcnt_n;
            fw      <= (state_n == FWD);
            bk      <= (state_n == BCK);
        end
    end
endmodule

// File: rtl/tank_lever_mapper.sv
// Maps per-player 4-way joysticks to two-tread drive commands, with input
// debouncing and a dead-time on tread reversal. Channels are fully independent.
module tank_lever_mapper
    import tank_ctrl_pkg::*;
#(
    parameter int NUM_PLAYERS  = 2,
    parameter int FILTER_TICKS = 2,
    parameter int DEAD_TICKS   = 3
) (
    input  logic               clk_sys,
    input  logic               reset,
    tank_lever_mapper_if.slave bus
);
    logic [NUM_PLAYERS-1:0][1:0] fw_v, bk_v;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        logic [3:0]       code, prev_q, acc_q, acc_n;
        logic [CNT_W-1:0] cnt_q, cnt_n;
        tgt_pair_t        tgt;

        assign code = bus.joy[4*p +: 4];

        // The trees see the code accepted on this very tick, not last tick's.
        always_comb begin
            if (code != prev_q)        cnt_n = CNT_W'(1);
            else if (cnt_q == CNT_MAX) cnt_n = cnt_q;
            else                       cnt_n = cnt_q + CNT_W'(1);
            acc_n = (cnt_n >= CNT_W'(FILTER_TICKS)) ? code : acc_q;
            tgt   = bus.mode ? direct_decode(acc_n) : table_decode(acc_n);
        end

        always_ff @(posedge clk_sys) begin
            if (reset) begin
                prev_q <= '0;
                acc_q  <= '0;
                cnt_q  <= '0;
            end else if (bus.tick) begin
                prev_q <= code;
                acc_q  <= acc_n;
                cnt_q  <= cnt_n;
            end
        end

        tread_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_tread_a (
            .clk_sys(clk_sys), .reset(reset), .tick(bus.tick),
            .target(tgt.a), .fw(fw_v[p][0]), .bk(bk_v[p][0])
        );
        tread_fsm #(.DEAD_TICKS(DEAD_TICKS)) u_tread_b (
            .clk_sys(clk_sys), .reset(reset), .tick(bus.tick),
            .target(tgt.b), .fw(fw_v[p][1]), .bk(bk_v[p][1])
        );
    end

    assign bus.tread_fw = fw_v;
    assign bus.tread_bk = bk_v;
endmodule

// File: tb/tb_tank_lever_mapper.sv
// Scoreboarded bench: the driver predicts each cycle's outputs from a
// sample-history model, the monitor compares them one cycle later.
module tb_tank_lever_mapper;
    localparam int NP = 3;
    localparam int FT = 2;
    localparam int DT = 3;
    localparam int JW = 4*NP;
    localparam int OW = 2*NP;

    logic clk_sys = 1'b0;
    logic reset   = 1'b1;
    always #5 clk_sys = ~clk_sys;

    tank_lever_mapper_if #(.NUM_PLAYERS(NP)) bus ();

    tank_lever_mapper #(
        .NUM_PLAYERS(NP), .FILTER_TICKS(FT), .DEAD_TICKS(DT)
    ) dut (
        .clk_sys(clk_sys), .reset(reset), .bus(bus)
    );

    typedef struct {
        logic [OW-1:0] fw;
        logic [OW-1:0] bk;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Model: last FT samples per player, accepted code, tread direction (+1/0/-1), dwell left.
    logic [3:0] hist [NP][$];
    logic [3:0] acc  [NP];
    int         dir  [NP][2];
    int         dead [NP][2];

    function automatic int table_target(input logic [3:0] c, input int side);
        int a, b;
        case (c)
            4'b1010: begin a = 0;  b = 1;  end
            4'b1000: begin a = 1;  b = 1;  end
            4'b1001: begin a = 1;  b = 0;  end
            4'b0001: begin a = 1;  b = -1; end
            4'b0101: begin a = -1; b = 0;  end
            4'b0100: begin a = -1; b = -1; end
            4'b0110: begin a = 0;  b = -1; end
            4'b0010: begin a = -1; b = 1;  end
            default: begin a = 0;  b = 0;  end
        endcase
        return (side != 0) ? b : a;
    endfunction

    function automatic int direct_target(input logic [3:0] c, input int side);
        logic [1:0] ax;
        ax = (side != 0) ? c[1:0] : c[3:2];
        if (ax == 2'b10) return 1;
        if (ax == 2'b01) return -1;
        return 0;
    endfunction

    function automatic void model_step(input logic rst, input logic tk, input logic md,
                                       input logic [JW-1:0] j);
        logic [3:0] c;
        bit         stable;
        int         tgt;
        for (int p = 0; p < NP; p++) begin
            if (rst) begin
                hist[p].delete();
                acc[p] = 4'h0;
                for (int t = 0; t < 2; t++) begin dir[p][t] = 0; dead[p][t] = 0; end
            end else if (tk) begin
                c = j[4*p +: 4];
                hist[p].push_back(c);
                if (hist[p].size() > FT) void'(hist[p].pop_front());
                stable = (hist[p].size() == FT);
                for (int k = 0; k < hist[p].size(); k++)
                    if (hist[p][k] != c) stable = 1'b0;
                if (stable) acc[p] = c;
                for (int t = 0; t < 2; t++) begin
                    tgt = md ? direct_target(acc[p], t) : table_target(acc[p], t);
                    if (dead[p][t] > 0) begin
                        dead[p][t]--;
                        if (dead[p][t] == 0) dir[p][t] = tgt;
                    end else if (dir[p][t] * tgt < 0) begin
                        dir[p][t]  = 0;
                        dead[p][t] = DT;
                    end else begin
                        dir[p][t] = tgt;
                    end
                end
            end
        end
    endfunction

    function automatic logic [JW-1:0] pj(input int p, input logic [3:0] c);
        logic [JW-1:0] v;
        v = '0;
        v[4*p +: 4] = c;
        return v;
    endfunction

    task automatic cyc(input logic rst, input logic tk, input logic md, input logic [JW-1:0] j);
        exp_t e;
        @(negedge clk_sys);
        reset    = rst;
        bus.tick = tk;
        bus.mode = md;
        bus.joy  = j;
        model_step(rst, tk, md, j);
        for (int p = 0; p < NP; p++)
            for (int t = 0; t < 2; t++) begin
                e.fw[2*p+t] = (dir[p][t] == 1);
                e.bk[2*p+t] = (dir[p][t] == -1);
            end
        exp_q.push_back(e);
    endtask

    task automatic wait_edge();
        @(posedge clk_sys);
        #2;
    endtask

    task automatic chk(input string name, input logic [OW-1:0] fw_exp, input logic [OW-1:0] bk_exp);
        checks++;
        if (bus.tread_fw !== fw_exp || bus.tread_bk !== bk_exp) begin
            errors++;
            $display("FAIL %s: got fw=%b bk=%b, want fw=%b bk=%b",
                     name, bus.tread_fw, bus.tread_bk, fw_exp, bk_exp);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk_sys);
            #1;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                checks++;
                if (bus.tread_fw !== e.fw || bus.tread_bk !== e.bk ||
                    (bus.tread_fw & bus.tread_bk) != '0) begin
                    errors++;
                    $display("FAIL scoreboard t=%0t: got fw=%b bk=%b, want fw=%b bk=%b",
                             $time, bus.tread_fw, bus.tread_bk, e.fw, e.bk);
                end
            end
        end
    end

    initial begin : driver
        logic [JW-1:0] j;
        logic          md, tk, rst;
        bit            slow;
        bus.tick = 1'b0;
        bus.mode = 1'b0;
        bus.joy  = '0;

        cyc(1'b1, 1'b0, 1'b0, '0);
        cyc(1'b1, 1'b0, 1'b0, '0);
        chk("reset_state", '0, '0);

        // Single-tick glitch is rejected, then a held forward is accepted.
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8)); wait_edge(); chk("glitch_1", '0, '0);
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h0)); wait_edge(); chk("glitch_2", '0, '0);
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8)); wait_edge(); chk("fwd_filter", '0, '0);
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8)); wait_edge(); chk("fwd_accept", 6'b000011, '0);

        // Reversal: neutral dwell of DT ticks after acceptance, then backward.
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h4)); wait_edge(); chk("rev_filter", 6'b000011, '0);
        for (int i = 0; i < DT; i++) begin
            cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h4)); wait_edge(); chk("rev_dead", '0, '0);
        end
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h4)); wait_edge(); chk("rev_bck", '0, 6'b000011);

        // Reset mid-dwell, then backward from neutral needs no dwell.
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8));
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8));
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h8)); wait_edge(); chk("dead_cnt2", '0, '0);
        cyc(1'b1, 1'b1, 1'b0, pj(0, 4'h8)); wait_edge(); chk("reset_in_dead", '0, '0);
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h4)); wait_edge(); chk("post_rst_filter", '0, '0);
        cyc(1'b0, 1'b1, 1'b0, pj(0, 4'h4)); wait_edge(); chk("post_rst_bck", '0, 6'b000011);

        // Mode flip re-decodes the held accepted code 0100: A back, B neutral.
        cyc(1'b0, 1'b1, 1'b1, pj(0, 4'h9)); wait_edge(); chk("mode_switch", '0, 6'b000001);

        // Direct mode from a clean start.
        cyc(1'b1, 1'b0, 1'b1, '0);
        cyc(1'b0, 1'b1, 1'b1, pj(0, 4'h9)); wait_edge(); chk("direct_filter", '0, '0);
        cyc(1'b0, 1'b1, 1'b1, pj(0, 4'h9)); wait_edge(); chk("direct_1001", 6'b000001, 6'b000010);
        cyc(1'b0, 1'b1, 1'b1, pj(0, 4'hC));
        cyc(1'b0, 1'b1, 1'b1, pj(0, 4'hC)); wait_edge(); chk("direct_1100", '0, '0);

        // Tick every 4th cycle, three independent channels.
        cyc(1'b1, 1'b0, 1'b0, '0);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, (i % 4) == 0, 1'b0, pj(2, 4'h4) | pj(0, 4'h8));
            wait_edge();
            if (i == 3) chk("slow_hold", '0, '0);
            if (i == 4) chk("slow_accept", 6'b000011, 6'b110000);
            if (i == 7) chk("slow_steady", 6'b000011, 6'b110000);
        end

        // Randomised traffic against the model.
        j    = '0;
        md   = 1'b0;
        slow = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int p = 0; p < NP; p++)
                if ($urandom_range(0, 3) == 0) j[4*p +: 4] = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 63) == 0)  md   = ~md;
            if ($urandom_range(0, 199) == 0) slow = ~slow;
            tk  = slow ? ((n % 4) == 0) : ($urandom_range(0, 7) != 0);
            rst = ($urandom_range(0, 299) == 0);
            cyc(rst, tk, md, j);
        end

        wait_edge();
        wait_edge();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
